// File: rtl/fpgbuddy_hex_scroller_if.sv
// Avalon-MM slave bus bundle for the hex scroller.
//   address    : 3-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, driven combinationally by the slave
// master: the bus initiator (CPU / testbench); slave: the scroller.
interface fpgbuddy_hex_scroller_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/fpgbuddy_hex_scroller.sv
// Scrolling message display for six 7-segment digits.
// A 16-entry message buffer is shifted right-to-left through a six-digit
// window, one digit per step tick; the step period is programmable.
//   clk      : system clock, all state on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (zero wait states, combinational readdata)
//   hex5..0  : registered segment patterns, hex5 leftmost, active-low
// Register map: 0 CTRL {LOOP,EN}, 1 STATUS {DONE,BUSY}, 2 PERIOD, 3 LEN,
// 4 BUF (write-only: [11:8] index, [6:0] pattern), 5 POS, 6-7 reserved.
module fpgbuddy_hex_scroller #(
  parameter int         PERIOD_W = 24,
  parameter logic [6:0] BLANK    = 7'h7F
) (
  input  logic                        clk,
  input  logic                        reset_n,
  fpgbuddy_hex_scroller_if.slave      bus,
  output logic [6:0]                  hex0,
  output logic [6:0]                  hex1,
  output logic [6:0]                  hex2,
  output logic [6:0]                  hex3,
  output logic [6:0]                  hex4,
  output logic [6:0]                  hex5
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  state_t              state_r;
  logic [1:0]          ctrl_r;
  logic                done_r;
  logic [PERIOD_W-1:0] period_r;
  logic [4:0]          len_r;
  logic [4:0]          rd_r;
  logic [4:0]          step_r;
  logic [PERIOD_W-1:0] presc_r;
  logic [6:0]          win_r [6];
  logic [6:0]          msg_mem_r [16];

  logic                wr_s;
  logic                wr_ctrl_s;
  logic                wr_status_s;
  logic                wr_period_s;
  logic                wr_len_s;
  logic                wr_buf_s;
  logic [4:0]          len_clamp_s;
  logic [PERIOD_W-1:0] period_m1_s;
  logic                tick_s;
  logic                busy_s;
  logic [6:0]          new_digit_s;
  logic [4:0]          rd_next_s;
  logic [5:0]          step_next_s;
  logic                finish_s;
  logic [31:0]         rdata_s;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl_s   = wr_s && (bus.address == 3'd0);
  assign wr_status_s = wr_s && (bus.address == 3'd1);
  assign wr_period_s = wr_s && (bus.address == 3'd2);
  assign wr_len_s    = wr_s && (bus.address == 3'd3);
  assign wr_buf_s    = wr_s && (bus.address == 3'd4);
  assign busy_s      = (state_r == RUN);

  // LEN clamp and prescaler terminal count (PERIOD of 0 behaves as 1)
  always_comb begin
    len_clamp_s = 5'd0;
    period_m1_s = '0;
    if (bus.writedata > 32'd16) begin
      len_clamp_s = 5'd16;
    end else begin
      len_clamp_s = bus.writedata[4:0];
    end
    if (period_r == '0) begin
      period_m1_s = '0;
    end else begin
      period_m1_s = period_r - PERIOD_ONE;
    end
  end

  // >= rather than == so a PERIOD shrunk below the running count still ticks
  assign tick_s = busy_s && (presc_r >= period_m1_s);

  // Next digit entering the window and next read pointer for a step tick
  always_comb begin
    new_digit_s = BLANK;
    rd_next_s   = rd_r;
    if (rd_r < len_r) begin
      new_digit_s = msg_mem_r[rd_r[3:0]];
    end else begin
      new_digit_s = BLANK;
    end
    if (ctrl_r[1]) begin
      // Loop: wrap after LEN-1, and also when LEN was cut below rd
      if ((rd_r + 5'd1) >= len_r) begin
        rd_next_s = 5'd0;
      end else begin
        rd_next_s = rd_r + 5'd1;
      end
    end else begin
      // One-shot: saturate at LEN so the tail scrolls in BLANK
      if (rd_r < len_r) begin
        rd_next_s = rd_r + 5'd1;
      end else begin
        rd_next_s = rd_r;
      end
    end
  end

  // One-shot completes after LEN+6 ticks: message fully scrolled off
  assign step_next_s = {1'b0, step_r} + 6'd1;
  assign finish_s    = ~ctrl_r[1] && (step_next_s >= ({1'b0, len_r} + 6'd6));

  // Message buffer, contents not reset
  always_ff @(posedge clk) begin
    if (wr_buf_s) begin
      msg_mem_r[bus.writedata[11:8]] <= bus.writedata[6:0];
    end
  end

  // Control FSM, register file, prescaler and display window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      ctrl_r   <= 2'd0;
      done_r   <= 1'b0;
      period_r <= '0;
      len_r    <= 5'd0;
      rd_r     <= 5'd0;
      step_r   <= 5'd0;
      presc_r  <= '0;
      for (int i = 0; i < 6; i++) begin
        win_r[i] <= BLANK;
      end
    end else begin
      if (wr_period_s) begin
        period_r <= bus.writedata[PERIOD_W-1:0];
      end
      if (wr_len_s) begin
        len_r <= len_clamp_s;
      end
      // A DONE set later in this block overrides this clear
      if (wr_status_s && bus.writedata[1]) begin
        done_r <= 1'b0;
      end
      if (wr_ctrl_s) begin
        // CTRL write has priority; any coincident tick is dropped
        ctrl_r <= bus.writedata[1:0];
        if (bus.writedata[0]) begin
          state_r <= RUN;
          done_r  <= 1'b0;
          rd_r    <= 5'd0;
          step_r  <= 5'd0;
          presc_r <= '0;
          for (int i = 0; i < 6; i++) begin
            win_r[i] <= BLANK;
          end
        end else if (state_r == RUN) begin
          state_r <= IDLE;
        end
      end else if (state_r == RUN) begin
        if (tick_s) begin
          presc_r <= '0;
          for (int i = 5; i > 0; i--) begin
            win_r[i] <= win_r[i-1];
          end
          win_r[0] <= new_digit_s;
          rd_r     <= rd_next_s;
          if (step_r != 5'd31) begin
            step_r <= step_r + 5'd1;
          end
          if (finish_s) begin
            state_r   <= DONE;
            done_r    <= 1'b1;
            ctrl_r[0] <= 1'b0;
            for (int i = 0; i < 6; i++) begin
              win_r[i] <= BLANK;
            end
          end
        end else begin
          presc_r <= presc_r + PERIOD_ONE;
        end
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    rdata_s = 32'd0;
    case (bus.address)
      3'd0:    rdata_s = {30'd0, ctrl_r};
      3'd1:    rdata_s = {30'd0, done_r, busy_s};
      3'd2:    rdata_s[PERIOD_W-1:0] = period_r;
      3'd3:    rdata_s = {27'd0, len_r};
      3'd5:    rdata_s = {27'd0, rd_r};
      default: rdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = rdata_s;

  assign hex0 = win_r[0];
  assign hex1 = win_r[1];
  assign hex2 = win_r[2];
  assign hex3 = win_r[3];
  assign hex4 = win_r[4];
  assign hex5 = win_r[5];

endmodule

// File: tb/tb_fpgbuddy_hex_scroller.sv
// Directed testbench for fpgbuddy_hex_scroller: reset state, one-shot and
// looping scroll, PERIOD 0/1 equivalence, stop on a tick cycle, DONE clear,
// asynchronous reset mid-run and LEN clamping.
module tb_fpgbuddy_hex_scroller;
  localparam logic [6:0] BL = 7'h7F;

  logic clk;
  logic reset_n;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  int n_assert;
  int n_fail;

  fpgbuddy_hex_scroller_if bus ();

  fpgbuddy_hex_scroller #(.PERIOD_W(24), .BLANK(7'h7F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, {32'd0, bus.readdata}, {32'd0, exp});
  endtask

  task automatic chk_win(input string tag, input logic [41:0] exp);
    check(tag, {22'd0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'd0, exp});
  endtask

  // Drive a write now; it commits on the next rising edge, returns at negedge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_win("win_in_reset", {6{BL}});
    reset_n = 1'b1;
    @(negedge clk);
    chk_win("win_after_reset", {6{BL}});
    for (int a = 0; a < 8; a++) begin
      chk_reg($sformatf("rd_reset_a%0d", a), 3'(a), 32'd0);
      @(negedge clk);
    end

    // One-shot scroll: BUF 0..2 = 40,79,24; LEN=3; PERIOD=4
    wr(3'd4, 32'h0000_0040);
    wr(3'd4, 32'h0000_0179);
    wr(3'd4, 32'h0000_0224);
    wr(3'd3, 32'd3);
    wr(3'd2, 32'd4);
    chk_reg("len_rb", 3'd3, 32'd3);
    chk_reg("period_rb", 3'd2, 32'd4);
    chk_reg("buf_rd_zero", 3'd4, 32'd0);
    @(negedge clk);
    wr(3'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk_win("os_before_tick1", {6{BL}});
    chk_reg("os_busy", 3'd1, 32'd1);
    @(negedge clk);
    chk_win("os_tick1", {BL, BL, BL, BL, BL, 7'h40});
    chk_reg("os_pos1", 3'd5, 32'd1);
    repeat (8) @(negedge clk);
    chk_win("os_tick3", {BL, BL, BL, 7'h40, 7'h79, 7'h24});
    repeat (23) @(negedge clk);
    chk_win("os_tick8", {7'h24, BL, BL, BL, BL, BL});
    chk_reg("os_busy_before_done", 3'd1, 32'd1);
    @(negedge clk);
    chk_win("os_done_win", {6{BL}});
    chk_reg("os_status_done", 3'd1, 32'd2);
    chk_reg("os_ctrl_en_clr", 3'd0, 32'd0);
    chk_reg("os_pos_sat", 3'd5, 32'd3);
    @(negedge clk);
    wr(3'd2, 32'd4);
    chk_reg("done_persists", 3'd1, 32'd2);
    @(negedge clk);
    wr(3'd1, 32'd2);
    chk_reg("done_cleared", 3'd1, 32'd0);
    @(negedge clk);

    // Looping scroll
    wr(3'd0, 32'd3);
    repeat (4) @(negedge clk);
    chk_reg("loop_pos_t1", 3'd5, 32'd1);
    repeat (4) @(negedge clk);
    chk_reg("loop_pos_t2", 3'd5, 32'd2);
    repeat (4) @(negedge clk);
    chk_reg("loop_pos_t3", 3'd5, 32'd0);
    chk_win("loop_win_t3", {BL, BL, BL, 7'h40, 7'h79, 7'h24});
    repeat (4) @(negedge clk);
    chk_reg("loop_pos_t4", 3'd5, 32'd1);
    chk_win("loop_win_t4", {BL, BL, 7'h40, 7'h79, 7'h24, 7'h40});
    for (int i = 0; i < 100; i++) begin
      repeat (4) @(negedge clk);
      chk_reg($sformatf("loop_busy_%0d", i), 3'd1, 32'd1);
    end

    // Stop on a tick cycle (tick 105 would land on the CTRL write edge)
    repeat (3) @(negedge clk);
    wr(3'd0, 32'd0);
    chk_win("stop_win_frozen", {7'h24, 7'h40, 7'h79, 7'h24, 7'h40, 7'h79});
    chk_reg("stop_status", 3'd1, 32'd0);
    chk_reg("stop_pos", 3'd5, 32'd2);
    repeat (8) @(negedge clk);
    chk_win("stop_win_hold", {7'h24, 7'h40, 7'h79, 7'h24, 7'h40, 7'h79});

    // PERIOD=0 then PERIOD=1: one tick per cycle, DONE after 9 cycles
    for (int p = 0; p < 2; p++) begin
      wr(3'd2, 32'(p));
      wr(3'd0, 32'd1);
      chk_reg($sformatf("p%0d_start_status", p), 3'd1, 32'd1);
      @(negedge clk);
      chk_win($sformatf("p%0d_t1", p), {BL, BL, BL, BL, BL, 7'h40});
      @(negedge clk);
      chk_win($sformatf("p%0d_t2", p), {BL, BL, BL, BL, 7'h40, 7'h79});
      repeat (6) @(negedge clk);
      chk_reg($sformatf("p%0d_busy_t8", p), 3'd1, 32'd1);
      @(negedge clk);
      chk_reg($sformatf("p%0d_done_t9", p), 3'd1, 32'd2);
      chk_win($sformatf("p%0d_done_win", p), {6{BL}});
      @(negedge clk);
    end

    // Asynchronous reset mid-run
    wr(3'd2, 32'd4);
    wr(3'd0, 32'd1);
    repeat (5) @(negedge clk);
    chk_win("ar_before", {BL, BL, BL, BL, BL, 7'h40});
    #1;
    reset_n = 1'b0;
    #1;
    chk_win("ar_blank_async", {6{BL}});
    chk_reg("ar_status", 3'd1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reg("ar_idle", 3'd1, 32'd0);
    chk_reg("ar_period", 3'd2, 32'd0);
    @(negedge clk);
    wr(3'd3, 32'd20);
    chk_reg("len_clamp", 3'd3, 32'd16);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
